ysyx_22040088_ifu: RTL and testbench

Instruction fetch unit for the NPC core. It holds the architectural PC and fetches one 32-bit instruction per retire over a valid/ready read channel. It presents the instruction to decode with a valid/ready handshake. On retire it latches the next PC produced by the next-PC select stage. It sits directly downstream of `ysyx_22040088_gennextpc` and upstream of decode.

---
 rtl/ysyx_22040088_pkg.sv | 14 +
 rtl/ysyx_22040088_pcreg.sv | 18 +
 rtl/ysyx_22040088_ifu.sv | 82 ++++++++
 tb/tb_ysyx_22040088_ifu.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/ysyx_22040088_pkg.sv
// ysyx_22040088_pkg: shared fetch-unit types and constants
package ysyx_22040088_pkg;
    typedef enum logic [2:0] {
        BOOT = 3'd0,
        REQ  = 3'd1,
        RESP = 3'd2,
        OUT  = 3'd3,
        EXEC = 3'd4,
        ERR  = 3'd5
    } ifu_state_t;

    localparam logic [1:0]  RESP_OKAY        = 2'b00;
    localparam logic [63:0] DEFAULT_RESET_PC = 64'h0000_0000_8000_0000;
endpackage

// File: rtl/ysyx_22040088_pcreg.sv
// ysyx_22040088_pcreg: 64-bit PC register with write enable and async reset
import ysyx_22040088_pkg::*;

module ysyx_22040088_pcreg #(
    parameter logic [63:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wen,
    input  logic [63:0] d,
    output logic [63:0] q
);
    // PC only moves on a taken retire
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) q <= RESET_PC;
        else if (wen) q <= d;
    end
endmodule

// File: rtl/ysyx_22040088_ifu.sv
// ysyx_22040088_ifu: instruction fetch unit holding the PC and a one-deep fetch pipeline
import ysyx_22040088_pkg::*;

module ysyx_22040088_ifu #(
    parameter logic [63:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [63:0] nextpc,
    input  logic        pc_wen,
    output logic [63:0] araddr,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rvalid,
    output logic        rready,
    output logic [63:0] pc,
    output logic [31:0] inst,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic        fetch_err
);
    ifu_state_t state, state_nxt;
    logic       pc_take;
    logic       misalign;
    logic       resp_take;

    assign misalign  = nextpc[1:0] != 2'b00;
    assign resp_take = state == RESP && rvalid;

    // Next state and PC-write decision; a misaligned target still updates the PC
    always_comb begin
        state_nxt = state;
        pc_take   = 1'b0;
        case (state)
            BOOT: state_nxt = REQ;
            REQ:  if (arready) state_nxt = RESP;
            RESP: if (rvalid) state_nxt = (rresp != RESP_OKAY) ? ERR : OUT;
            OUT:  if (inst_ready) begin
                pc_take   = pc_wen;
                state_nxt = pc_wen ? (misalign ? ERR : REQ) : EXEC;
            end
            EXEC: if (pc_wen) begin
                pc_take   = 1'b1;
                state_nxt = misalign ? ERR : REQ;
            end
            ERR:  state_nxt = ERR;
            default: state_nxt = BOOT;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= BOOT;
        else state <= state_nxt;
    end

    // Instruction capture on the accepted response, and sticky error flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inst      <= 32'h0;
            fetch_err <= 1'b0;
        end else begin
            if (resp_take) inst <= rdata;
            if ((resp_take && rresp != RESP_OKAY) || (pc_take && misalign)) fetch_err <= 1'b1;
        end
    end

    ysyx_22040088_pcreg #(.RESET_PC(RESET_PC)) u_pcreg (
        .clk   (clk),
        .rst_n (rst_n),
        .wen   (pc_take),
        .d     (nextpc),
        .q     (pc)
    );

    assign araddr     = pc;
    assign arvalid    = state == REQ;
    assign rready     = state == RESP;
    assign inst_valid = state == OUT;
endmodule

// File: tb/tb_ysyx_22040088_ifu.sv
// tb_ysyx_22040088_ifu: directed table-driven bench for the fetch unit
module tb_ysyx_22040088_ifu;
    localparam logic [63:0] R = 64'h0000_0000_8000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] nextpc = '0;
    logic        pc_wen = 1'b0;
    logic [63:0] araddr;
    logic        arvalid;
    logic        arready = 1'b0;
    logic [31:0] rdata = '0;
    logic [1:0]  rresp = '0;
    logic        rvalid = 1'b0;
    logic        rready;
    logic [63:0] pc;
    logic [31:0] inst;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic        fetch_err;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic        ar, rv;
        logic [31:0] rdata;
        logic [1:0]  rresp;
        logic        ir, pw;
        logic [63:0] nextpc;
        logic        e_arv, e_rr, e_iv;
        logic [63:0] e_pc;
        logic [31:0] e_inst;
        logic        e_err;
    } vec_t;

    vec_t vecs[$];

    ysyx_22040088_ifu dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .nextpc     (nextpc),
        .pc_wen     (pc_wen),
        .araddr     (araddr),
        .arvalid    (arvalid),
        .arready    (arready),
        .rdata      (rdata),
        .rresp      (rresp),
        .rvalid     (rvalid),
        .rready     (rready),
        .pc         (pc),
        .inst       (inst),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .fetch_err  (fetch_err)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(logic ar, logic rv, logic [31:0] rd, logic [1:0] rr, logic ir, logic pw,
                                logic [63:0] np, logic e_arv, logic e_rr, logic e_iv, logic [63:0] e_pc,
                                logic [31:0] e_inst, logic e_err);
        vec_t v;
        v.ar = ar; v.rv = rv; v.rdata = rd; v.rresp = rr; v.ir = ir; v.pw = pw; v.nextpc = np;
        v.e_arv = e_arv; v.e_rr = e_rr; v.e_iv = e_iv; v.e_pc = e_pc; v.e_inst = e_inst; v.e_err = e_err;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic e_arv, input logic e_rr, input logic e_iv,
                           input logic [63:0] e_pc, input logic [31:0] e_inst, input logic e_err);
        chk({tag, ".arvalid"}, 64'(arvalid), 64'(e_arv));
        chk({tag, ".rready"}, 64'(rready), 64'(e_rr));
        chk({tag, ".inst_valid"}, 64'(inst_valid), 64'(e_iv));
        chk({tag, ".pc"}, pc, e_pc);
        chk({tag, ".araddr"}, araddr, e_pc);
        chk({tag, ".inst"}, 64'(inst), 64'(e_inst));
        chk({tag, ".fetch_err"}, 64'(fetch_err), 64'(e_err));
    endtask

    task automatic drive(input logic ar, input logic rv, input logic [31:0] rd, input logic [1:0] rr,
                         input logic ir, input logic pw, input logic [63:0] np);
        arready = ar; rvalid = rv; rdata = rd; rresp = rr; inst_ready = ir; pc_wen = pw; nextpc = np;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        drive(0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        vecs.push_back(mk(1,1,32'h13,0,0,0,0,            1,0,0,R,0,0));
        vecs.push_back(mk(1,1,32'h13,0,0,0,0,            0,1,0,R,0,0));
        vecs.push_back(mk(1,1,32'h13,0,0,0,0,            0,0,1,R,32'h13,0));
        vecs.push_back(mk(1,1,32'h13,0,1,1,R+4,          1,0,0,R+4,32'h13,0));
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(0,1,32'hBAD0BAD0,0,1,1,64'hDEAD0000, 1,0,0,R+4,32'h13,0));
        vecs.push_back(mk(1,0,32'h0,0,0,0,0,             0,1,0,R+4,32'h13,0));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(0,0,32'hFFFFFFFF,0,0,1,64'hDEAD0000, 0,1,0,R+4,32'h13,0));
        vecs.push_back(mk(0,1,32'h00100093,0,0,0,0,      0,0,1,R+4,32'h00100093,0));
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk(0,1,32'hBAD0BAD0,0,0,1,64'hDEAD0000, 0,0,1,R+4,32'h00100093,0));
        vecs.push_back(mk(0,0,0,0,1,0,0,                 0,0,0,R+4,32'h00100093,0));
        vecs.push_back(mk(0,0,0,0,0,0,0,                 0,0,0,R+4,32'h00100093,0));
        vecs.push_back(mk(0,0,0,0,0,1,R+64'h100,         1,0,0,R+64'h100,32'h00100093,0));
        vecs.push_back(mk(1,0,0,0,0,0,0,                 0,1,0,R+64'h100,32'h00100093,0));
        vecs.push_back(mk(1,1,32'hAAAA5555,2'b10,0,0,0,  0,0,0,R+64'h100,32'hAAAA5555,1));
        for (int i = 0; i < 2; i++)
            vecs.push_back(mk(1,1,32'h13,0,1,1,R+64'h200, 0,0,0,R+64'h100,32'hAAAA5555,1));

        do_reset();
        chk_all("reset", 0, 0, 0, R, 0, 0);
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].ar, vecs[i].rv, vecs[i].rdata, vecs[i].rresp, vecs[i].ir, vecs[i].pw, vecs[i].nextpc);
            step();
            chk_all($sformatf("vec%0d", i), vecs[i].e_arv, vecs[i].e_rr, vecs[i].e_iv,
                    vecs[i].e_pc, vecs[i].e_inst, vecs[i].e_err);
        end

        // misaligned retire target: PC still updated, then frozen in error
        do_reset();
        drive(1, 1, 32'h13, 0, 0, 0, 0);
        step(); step(); step();
        chk_all("mis.out", 0, 0, 1, R, 32'h13, 0);
        drive(1, 1, 32'h13, 0, 1, 1, R + 64'h2);
        step();
        chk_all("mis.err", 0, 0, 0, R + 64'h2, 32'h13, 1);
        drive(1, 1, 32'h13, 0, 1, 1, R + 64'h10);
        step(); step();
        chk_all("mis.frozen", 0, 0, 0, R + 64'h2, 32'h13, 1);

        // asynchronous reset while waiting in RESP after one retire
        do_reset();
        drive(1, 1, 32'h13, 0, 0, 0, 0);
        step(); step(); step();
        drive(1, 1, 32'h13, 0, 1, 1, R + 64'h8);
        step();
        drive(1, 0, 32'h13, 0, 0, 0, 0);
        step();
        chk_all("ar.resp", 0, 1, 0, R + 64'h8, 32'h13, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("ar.async", 0, 0, 0, R, 0, 0);
        step();
        rst_n = 1'b1;
        drive(1, 1, 32'h13, 0, 0, 0, 0);
        chk_all("ar.boot", 0, 0, 0, R, 0, 0);
        step();
        chk_all("ar.req", 1, 0, 0, R, 0, 0);
        step(); step();
        chk_all("ar.out", 0, 0, 1, R, 32'h13, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
